// File: rtl/car_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// car_ctrl_pkg
// Shared definitions for the remote-control car link: steering and throttle
// code encodings, the command frame header nibble and the transmitter state
// encoding. Imported by the keyboard decode stage, the command transmitter
// and the car-side receiver so that all three agree on the codes.
// -----------------------------------------------------------------------------
package car_ctrl_pkg;

  // Steering codes (direc)
  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  // Throttle codes (drive)
  localparam logic [1:0] DRV_STOP  = 2'b00;
  localparam logic [1:0] DRV_BACK  = 2'b01;
  localparam logic [1:0] DRV_FWD   = 2'b10;

  // Constant upper nibble of every command frame; lets the receiver reject
  // noise that happens to look like a valid start bit.
  localparam logic [3:0] CMD_HEADER = 4'hA;

  // Serial transmitter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // 2'b11 is not a legal code for either field (both keys pressed at once);
  // it is folded to the neutral code 2'b00.
  function automatic logic [1:0] sanitize_field(input logic [1:0] f);
    return (f == 2'b11) ? 2'b00 : f;
  endfunction

endpackage

// File: rtl/car_cmd_tx_if.sv
// -----------------------------------------------------------------------------
// car_cmd_tx_if
// Bundles the command inputs and serial-line outputs of car_cmd_tx.
//   direc    [1:0] steering code from the decode stage
//   drive    [1:0] throttle code from the decode stage
//   tx             serial line, idles high
//   busy           high while a frame is on the line
//   last_cmd [3:0] {drive,direc} of the most recently started frame
// master: the command source (decode stage / bench).
// slave : the transmitter.
// -----------------------------------------------------------------------------
interface car_cmd_tx_if;
  logic [1:0] direc;
  logic [1:0] drive;
  logic       tx;
  logic       busy;
  logic [3:0] last_cmd;

  modport master (
    output direc,
    output drive,
    input  tx,
    input  busy,
    input  last_cmd
  );

  modport slave (
    input  direc,
    input  drive,
    output tx,
    output busy,
    output last_cmd
  );
endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts BAUD_DIV enabled clock cycles and pulses bit_done_o on the last cycle
// of each serial bit period, then wraps.
//   clk        system clock
//   rst        asynchronous active-high reset
//   clear_i    restart the bit period (asserted in the cycle a frame is started)
//   en_i       count enable (high while a frame is on the line)
//   bit_done_o one-cycle pulse in the final cycle of a bit period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int BAUD_DIV = 10417
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/car_cmd_tx.sv
// -----------------------------------------------------------------------------
// car_cmd_tx
// Serial command transmitter for the remote-control car link. Packs the
// steering and throttle codes into the byte {CMD_HEADER, drive, direc} and
// sends it as an 8N1 frame, LSB first. A frame is started whenever the
// (sanitised) command differs from the last one sent, once after reset, and
// as a keepalive every KEEPALIVE_DIV cycles while the command is unchanged.
//   clk  system clock
//   rst  asynchronous active-high reset (aborts a frame, line goes idle)
//   bus  slave side of car_cmd_tx_if (direc/drive in; tx/busy/last_cmd out)
// -----------------------------------------------------------------------------
module car_cmd_tx #(
  parameter int          BAUD_DIV      = 10417,
  parameter int          KEEPALIVE_DIV = 10000000,
  parameter logic [3:0]  CMD_HEADER    = car_ctrl_pkg::CMD_HEADER
) (
  input  logic         clk,
  input  logic         rst,
  car_cmd_tx_if.slave  bus
);

  import car_ctrl_pkg::*;

  localparam int KW = $clog2(KEEPALIVE_DIV);
  localparam logic [KW-1:0] KA_LAST = KW'(KEEPALIVE_DIV - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] last_cmd_q, last_cmd_d;
  logic       force_q, force_d;
  logic [KW-1:0] ka_q, ka_d;

  logic [3:0] cmd_s;
  logic       trigger;
  logic       timer_clr;
  logic       bit_done;
  logic       busy;
  logic       tx;

  assign cmd_s = {sanitize_field(bus.drive), sanitize_field(bus.direc)};
  assign busy  = (state_q != ST_IDLE);

  uart_bit_timer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clr),
    .en_i       (busy),
    .bit_done_o (bit_done)
  );

  // Next-state and line output
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    last_cmd_d = last_cmd_q;
    force_d    = force_q;
    trigger    = 1'b0;
    timer_clr  = 1'b0;
    tx         = 1'b1;

    case (state_q)
      ST_IDLE: begin
        // Inputs are only looked at here; anything that changes during a
        // frame is picked up (as a level) in the first idle cycle.
        if (force_q || (cmd_s != last_cmd_q) || (ka_q == KA_LAST)) begin
          trigger    = 1'b1;
          timer_clr  = 1'b1;
          shift_d    = {CMD_HEADER, cmd_s};
          last_cmd_d = cmd_s;
          force_d    = 1'b0;
          bit_cnt_d  = 3'd0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_done) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        tx = shift_q[0];
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        tx = 1'b1;
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Keepalive counter runs in every state and saturates, so a keepalive that
  // falls due mid-frame is still pending when the frame ends.
  always_comb begin
    ka_d = ka_q;
    if (trigger) begin
      ka_d = '0;
    end else if (ka_q != KA_LAST) begin
      ka_d = ka_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      last_cmd_q <= 4'b0000;
      force_q    <= 1'b1;
      ka_q       <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      last_cmd_q <= last_cmd_d;
      force_q    <= force_d;
      ka_q       <= ka_d;
    end
  end

  // tx and busy decode only from registered state, so the asynchronous reset
  // returns the line to idle without waiting for a clock edge.
  assign bus.tx       = tx;
  assign bus.busy     = busy;
  assign bus.last_cmd = last_cmd_q;

endmodule

// File: tb/tb_car_cmd_tx.sv
module tb_car_cmd_tx;

  localparam int BAUD = 4;
  localparam int KA   = 200;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic [3:0] lc;
    bit         aborted;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  car_cmd_tx_if bus();

  car_cmd_tx #(
    .BAUD_DIV      (BAUD),
    .KEEPALIVE_DIV (KA),
    .CMD_HEADER    (4'hA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [7:0] d, input int s, input logic [3:0] lc, input bit ab);
    exp_t e;
    e.data = d; e.start = s; e.lc = lc; e.aborted = ab;
    return e;
  endfunction

  // Monitor: decodes frames off the line and checks them against the queue
  initial begin : monitor
    logic [9:0] bits;
    logic [3:0] lc;
    int         start;
    bit         aborted, consistent, busy_ok, gap_ok;
    exp_t       e;
    forever begin
      @(negedge clk); #2;
      if (!rst && bus.tx == 1'b0) begin
        start = cyc; aborted = 0; consistent = 1; busy_ok = 1; gap_ok = 0;
        bits = '0; lc = bus.last_cmd;
        for (int k = 0; k < 10 * BAUD; k++) begin
          if (k > 0) begin @(negedge clk); #2; end
          if (rst) begin aborted = 1; break; end
          if (bus.busy !== 1'b1) busy_ok = 0;
          if (k % BAUD == 0) bits[k / BAUD] = bus.tx;
          else if (bus.tx !== bits[k / BAUD]) consistent = 0;
        end
        if (!aborted) begin
          @(negedge clk); #2;
          gap_ok = (bus.busy == 1'b0) && (bus.tx == 1'b1);
        end
        $display("frame start=%0d byte=%02h last_cmd=%04b aborted=%0d", start, bits[8:1], lc, aborted);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", start, -1);
        end else begin
          e = exp_q.pop_front();
          chk("frame_start_cycle", start, e.start);
          chk("frame_aborted", int'(aborted), int'(e.aborted));
          if (!aborted) begin
            chk("frame_byte", bits[8:1], e.data);
            chk("start_bit", bits[0], 0);
            chk("stop_bit", bits[9], 1);
            chk("bit_hold", int'(consistent), 1);
            chk("busy_40", int'(busy_ok), 1);
            chk("last_cmd", lc, e.lc);
            chk("idle_gap", int'(gap_ok), 1);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    int r, s;
    bus.direc = 2'b00;
    bus.drive = 2'b00;
    r = 5;
    wait_until(2);
    chk("reset_tx", bus.tx, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_last_cmd", bus.last_cmd, 0);

    // 1: forced frame after reset release
    wait_until(r);
    exp_q.push_back(mk(8'hA0, r + 1, 4'b0000, 0));
    rst = 1'b0;

    // 2: command change -> next cycle frame
    wait_until(r + 45);
    exp_q.push_back(mk(8'hAA, r + 46, 4'b1010, 0));
    bus.direc = 2'b10; bus.drive = 2'b10;

    // 3: change mid-frame is deferred to the first idle cycle
    wait_until(r + 55);
    exp_q.push_back(mk(8'hA6, r + 87, 4'b0110, 0));
    bus.drive = 2'b01;

    // 4: back to 0000, then direc=11 which sanitises to 00 -> keepalive only
    wait_until(r + 130);
    exp_q.push_back(mk(8'hA0, r + 131, 4'b0000, 0));
    bus.direc = 2'b00; bus.drive = 2'b00;
    wait_until(r + 175);
    bus.direc = 2'b11;
    // 5: keepalive frames every 200 cycles; the last one gets reset-aborted
    for (int i = 1; i <= 6; i++)
      exp_q.push_back(mk(8'hA0, r + 131 + KA * i, 4'b0000, 0));
    exp_q.push_back(mk(8'hA0, r + 131 + KA * 7, 4'b0000, 1));

    // 6: asynchronous reset 15 cycles into a frame
    wait_until(r + 131 + KA * 7 + 14);
    chk("busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", bus.tx, 1);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_last_cmd", bus.last_cmd, 0);
    s = cyc + 5;
    wait_until(s);
    exp_q.push_back(mk(8'hA0, s + 1, 4'b0000, 0));
    rst = 1'b0;

    wait_until(s + 70);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule
